// File: rtl/spi_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single SPI memory: 8-bit command, 24-bit address, 32-bit data frame.
// Optional write support is enabled by defining SPI_MEM_WRITE_EN; otherwise every data request is a read.
module spi_mem_arbiter #(
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter logic [7:0] WRITE_CMD = 8'h02
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_req,
    input  logic [23:0] i_addr,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [23:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] rdata,
    input  logic        spi_miso,
    output logic        spi_select,
    output logic        spi_mosi,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_bit_cnt;
    logic [63:0] r_shift;
    logic        r_is_read;
    logic        r_grant_fetch;
    logic        r_last_fetch;
    logic        r_select;
    logic        r_mosi;
    logic        r_i_ack;
    logic        r_d_ack;
    logic [31:0] r_rdata;

    logic        w_any_req;
    logic        w_grant_fetch;
    logic        w_d_write;
    logic [31:0] w_d_wdata;
    logic        w_is_write;
    logic        w_last_bit;
    logic [63:0] w_frame;

`ifdef SPI_MEM_WRITE_EN
    assign w_d_write = d_we;
    assign w_d_wdata = d_wdata;
`else
    assign w_d_write = 1'b0;
    assign w_d_wdata = 32'h0;
    logic w_unused_write;
    assign w_unused_write = ^{d_we, d_wdata};
`endif

    // On contention the port that lost last time wins; a lone request always wins.
    assign w_any_req     = i_req | d_req;
    assign w_grant_fetch = i_req && (!d_req || !r_last_fetch);
    assign w_is_write    = !w_grant_fetch && w_d_write;
    assign w_last_bit    = (r_bit_cnt == 6'd63);

    always_comb begin
        w_frame = {READ_CMD, i_addr, 32'h0};
        if (!w_grant_fetch) begin
            w_frame = {(w_is_write ? WRITE_CMD : READ_CMD), d_addr,
                       (w_is_write ? w_d_wdata : 32'h0)};
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last_bit) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 6'd0;
            r_shift       <= 64'h0;
            r_is_read     <= 1'b1;
            r_grant_fetch <= 1'b0;
            r_last_fetch  <= 1'b0;
            r_select      <= 1'b1;
            r_mosi        <= 1'b0;
            r_i_ack       <= 1'b0;
            r_d_ack       <= 1'b0;
            r_rdata       <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_fetch <= w_grant_fetch;
                        r_last_fetch  <= w_grant_fetch;
                        r_is_read     <= !w_is_write;
                        r_select      <= 1'b0;
                        r_mosi        <= w_frame[63];
                        r_shift       <= {w_frame[62:0], 1'b0};
                        r_bit_cnt     <= 6'd0;
                    end
                end
                ST_SHIFT: begin
                    // Bits 32..63 are the data phase; miso is captured at the edge ending each bit.
                    if (r_is_read && r_bit_cnt[5]) begin
                        r_rdata <= {r_rdata[30:0], spi_miso};
                    end
                    if (w_last_bit) begin
                        r_select  <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_bit_cnt <= 6'd0;
                        r_i_ack   <= r_grant_fetch;
                        r_d_ack   <= !r_grant_fetch;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        r_mosi    <= r_shift[63];
                        r_shift   <= {r_shift[62:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_ack      = r_i_ack;
    assign d_ack      = r_d_ack;
    assign rdata      = r_rdata;
    assign spi_select = r_select;
    assign spi_mosi   = r_mosi;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/spi_mem_arbiter.md
SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 SHALL have parameter READ_CMD, default 8'h03, SPI read command byte.
REQ-002 SHALL have parameter WRITE_CMD, default 8'h02, SPI write command byte.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge; SPI clock is !clk externally.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_req  input  1  instruction-fetch request; held with i_addr until i_ack.
REQ-006 SHALL have port i_addr  input  24  fetch byte address.
REQ-007 SHALL have port i_ack  output  1  one-cycle fetch completion pulse; rdata valid same cycle.
REQ-008 SHALL have port d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_ack.
REQ-009 SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port d_addr  input  24  data byte address.
REQ-011 SHALL have port d_wdata  input  32  write data, MSB sent first.
REQ-012 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-013 SHALL have port rdata  output  32  read word shared by both ports.
REQ-014 SHALL have port spi_miso  input  1  serial read data, already negedge-buffered upstream.
REQ-015 SHALL have port spi_select  output  1  chip select, active-low, registered.
REQ-016 SHALL have port spi_mosi  output  1  serial command/address/write data, registered.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, SHIFT, DONE.
REQ-019 SHALL in IDLE, with any req high, latch granted port's command/address/data, enter SHIFT, drive spi_select=0 from next cycle.
REQ-020 SHALL arbitrate when both reqs high: grant port not granted last; last-grant resets to data, so fetch wins first contention.
REQ-021 SHALL hold spi_select=0 for exactly 64 SHIFT cycles, bit counter 0..63.
REQ-022 SHALL drive spi_mosi, MSB first: bits 0-7 command, 8-31 address, 32-63 d_wdata on writes, 0 on reads.
REQ-023 SHALL on reads shift spi_miso into rdata at the posedge ending each of bits 32-63, MSB first.
REQ-024 SHALL after bit 63 enter DONE for one cycle: spi_select=1, spi_mosi=0, pulse granted port's ack only.
REQ-025 SHALL return DONE -> IDLE unconditionally; requests not sampled in DONE; select high >=2 cycles between transactions.
REQ-026 SHALL give fixed latency: req sampled in IDLE at cycle 0 -> ack in cycle 65.
REQ-027 SHALL hold rdata stable from DONE until next read's first data bit; writes leave rdata unchanged.
REQ-028 SHALL complete a started transaction and pulse ack even if req drops mid-transaction.
REQ-029 SHALL never assert i_ack and d_ack together.

Reset
REQ-030 SHALL on rstn low immediately force IDLE, spi_select=1, spi_mosi=0, i_ack=0, d_ack=0, busy=0, rdata=0, counter=0, last-grant=data.
REQ-031 SHALL on reset mid-transaction abort without ack; requester re-issues after release.

Configuration
REQ-032 SHALL with SPI_MEM_WRITE_EN defined support writes per REQ-022 using WRITE_CMD.
REQ-033 SHALL without SPI_MEM_WRITE_EN ignore d_we and d_wdata, treating every data request as a read with READ_CMD.

Verification
REQ-034 SHALL cover fetch read: i_req, i_addr=24'h000100, miso word 32'hDEADBEEF -> mosi 8'h03,24'h000100; i_ack cycle 65; rdata=32'hDEADBEEF.
REQ-035 SHALL cover write (macro on): d_req,d_we=1,d_addr=24'h001234,d_wdata=32'hCAFEF00D -> mosi 8'h02,24'h001234,32'hCAFEF00D; d_ack; rdata unchanged.
REQ-036 SHALL cover contention after reset: i_req,d_req same cycle -> fetch first, data second, select high 2 cycles between, then alternation.
REQ-037 SHALL cover reset at bit 40 of read -> select=1 same cycle asynchronously, no ack, next request starts from bit 0.
REQ-038 SHALL cover macro off: d_we=1,d_wdata=32'hFFFFFFFF -> command 8'h03, mosi 0 in data phase, rdata captured from miso.
